mmio_resp_fabric: RTL and testbench

- Parametrised MMIO response fabric between the L2 MMIO port and N peripheral devices.
- Replaces ad-hoc combinational OK/data priority muxing with a registered, timed transaction engine.
- Selects the responding device by fixed priority and flags multi-responder collisions.
- Detects bus misses by timeout instead of address repetition and returns FAULT to the requester.

---
 rtl/mmio_resp_fabric_if.sv | 24 ++
 rtl/mmio_resp_fabric.sv | 194 +++++++++++++++++++
 tb/tb_mmio_resp_fabric.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_resp_fabric_if.sv
// L2 MMIO request/response bundle between the L2 port and the response fabric.
// The master side issues requests; the slave side returns registered status and data.
interface mmio_resp_fabric_if #(
    parameter int DATA_W = 64
);
    logic [31:0]       mmioAddr;
    logic [4:0]        mmioOpm;
    logic [DATA_W-1:0] mmioInData;
    logic [1:0]        mmioOK;

    modport master (
        output mmioAddr,
        output mmioOpm,
        input  mmioInData,
        input  mmioOK
    );

    modport slave (
        input  mmioAddr,
        input  mmioOpm,
        output mmioInData,
        output mmioOK
    );
endinterface

// File: rtl/mmio_resp_fabric.sv
// MMIO response fabric: fixed-priority device select, timeout bus-miss, collision flag.
// Optional interrupt/exception output is enabled with MMIO_FABRIC_IRQ_EN.
module mmio_resp_fabric #(
    parameter int NDEV    = 8,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    mmio_resp_fabric_if.slave      mmio,
    input  logic [NDEV*DATA_W-1:0] devOutData,
    input  logic [NDEV*2-1:0]      devOK,
    output logic                   busMissFlag,
    output logic [31:0]            busMissAddr,
    output logic                   collisionFlag,
    input  logic                   statClear
`ifdef MMIO_FABRIC_IRQ_EN
    ,
    input  logic [NDEV-1:0]        irqReq,
    input  logic                   tickIrq,
    output logic [63:0]            busExc
`endif
);

    localparam logic [1:0] OK_READY = 2'b00;
    localparam logic [1:0] OK_OK    = 2'b01;
    localparam logic [1:0] OK_HOLD  = 2'b10;
    localparam logic [1:0] OK_FAULT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        MISS,
        RESP
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;
    logic [31:0]       addrQ;
    logic [31:0]       addrNext;
    logic [1:0]        okQ;
    logic [1:0]        okNext;
    logic [DATA_W-1:0] dataQ;
    logic [DATA_W-1:0] dataNext;
    logic              missEvent;

    logic              anyResp;
    logic              multiResp;
    logic [1:0]        winOK;
    logic [DATA_W-1:0] winData;

    assign mmio.mmioOK     = okQ;
    assign mmio.mmioInData = dataQ;

    // Downward scan leaves the lowest non-READY channel as winner.
    always_comb begin
        winOK   = OK_READY;
        winData = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (devOK[i*2 +: 2] != OK_READY) begin
                winOK   = devOK[i*2 +: 2];
                winData = devOutData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        anyResp   = 1'b0;
        multiResp = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            if (devOK[i*2 +: 2] != OK_READY) begin
                multiResp = multiResp | anyResp;
                anyResp   = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        addrNext  = addrQ;
        okNext    = okQ;
        dataNext  = dataQ;
        missEvent = 1'b0;
        unique case (state)
            IDLE: begin
                if (mmio.mmioOpm != 5'd0) begin
                    addrNext  = mmio.mmioAddr;
                    cntNext   = '0;
                    okNext    = OK_HOLD;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (anyResp) begin
                    // A HOLD winner has claimed the access, so the timer stalls.
                    if (winOK != OK_HOLD) begin
                        okNext    = winOK;
                        dataNext  = winData;
                        stateNext = RESP;
                    end
                end else if (cnt == CNT_LAST) begin
                    okNext    = OK_FAULT;
                    dataNext  = '0;
                    missEvent = 1'b1;
                    stateNext = MISS;
                end else if (cnt != CNT_MAX) begin
                    cntNext = cnt + 1'b1;
                end
            end
            MISS, RESP: begin
                if (mmio.mmioOpm == 5'd0) begin
                    okNext    = OK_READY;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            addrQ <= '0;
            okQ   <= OK_READY;
            dataQ <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            addrQ <= addrNext;
            okQ   <= okNext;
            dataQ <= dataNext;
        end
    end

    // A new miss or collision wins over a clear in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busMissFlag   <= 1'b0;
            busMissAddr   <= '0;
            collisionFlag <= 1'b0;
        end else begin
            if (missEvent) begin
                busMissFlag <= 1'b1;
                if (!busMissFlag || statClear) begin
                    busMissAddr <= addrQ;
                end
            end else if (statClear) begin
                busMissFlag <= 1'b0;
                busMissAddr <= '0;
            end
            if (multiResp) begin
                collisionFlag <= 1'b1;
            end else if (statClear) begin
                collisionFlag <= 1'b0;
            end
        end
    end

`ifdef MMIO_FABRIC_IRQ_EN
    logic [63:0] excNext;

    always_comb begin
        excNext = '0;
        if (tickIrq) begin
            excNext = 64'h0000_0000_0000_C001;
        end else begin
            for (int i = NDEV - 1; i >= 0; i--) begin
                if (irqReq[i]) begin
                    excNext = {48'h0, 16'hC000 | 16'(i + 2)};
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busExc <= '0;
        end else begin
            busExc <= excNext;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_resp_fabric.sv
// Directed bench for mmio_resp_fabric: handshake, timeout miss, collision, reset abort.
// Covers the MMIO_FABRIC_IRQ_EN exception path when the macro is defined.
module tb_mmio_resp_fabric;

    localparam int NDEV    = 8;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 256;
    localparam int CNT_W   = 9;

    localparam logic [1:0] RDY = 2'b00;
    localparam logic [1:0] OKV = 2'b01;
    localparam logic [1:0] HLD = 2'b10;
    localparam logic [1:0] FLT = 2'b11;

    logic                   clock;
    logic                   reset;
    logic [NDEV*DATA_W-1:0] devOutData;
    logic [NDEV*2-1:0]      devOK;
    logic                   busMissFlag;
    logic [31:0]            busMissAddr;
    logic                   collisionFlag;
    logic                   statClear;
`ifdef MMIO_FABRIC_IRQ_EN
    logic [NDEV-1:0]        irqReq;
    logic                   tickIrq;
    logic [63:0]            busExc;
`endif

    int total;
    int bad;

    mmio_resp_fabric_if #(.DATA_W(DATA_W)) mmio ();

    mmio_resp_fabric #(
        .NDEV   (NDEV),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mmio         (mmio.slave),
        .devOutData   (devOutData),
        .devOK        (devOK),
        .busMissFlag  (busMissFlag),
        .busMissAddr  (busMissAddr),
        .collisionFlag(collisionFlag),
        .statClear    (statClear)
`ifdef MMIO_FABRIC_IRQ_EN
        ,
        .irqReq       (irqReq),
        .tickIrq      (tickIrq),
        .busExc       (busExc)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setDev(input int ch, input logic [1:0] ok,
                          input logic [63:0] data);
        devOK[ch*2 +: 2]              = ok;
        devOutData[ch*DATA_W +: DATA_W] = data;
    endtask

    task automatic clrDev();
        devOK      = '0;
        devOutData = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        mmio.mmioAddr = '0;
        mmio.mmioOpm  = '0;
        statClear     = 1'b0;
        clrDev();
`ifdef MMIO_FABRIC_IRQ_EN
        irqReq  = '0;
        tickIrq = 1'b0;
`endif
        step();
        step();
        chk("rst_ok", 64'(mmio.mmioOK), 64'(RDY));
        chk("rst_data", mmio.mmioInData, 64'h0);
        chk("rst_miss", 64'(busMissFlag), 64'h0);
        chk("rst_maddr", 64'(busMissAddr), 64'h0);
        chk("rst_coll", 64'(collisionFlag), 64'h0);
`ifdef MMIO_FABRIC_IRQ_EN
        chk("rst_exc", busExc, 64'h0);
`endif
        reset = 1'b0;
        step();

        // stale response in IDLE is ignored
        setDev(6, OKV, 64'h55);
        step();
        chk("stale_ok", 64'(mmio.mmioOK), 64'(RDY));
        chk("stale_data", mmio.mmioInData, 64'h0);
        clrDev();

        // channel 2: HOLD x3 then OK
        mmio.mmioAddr = 32'h0000_1000;
        mmio.mmioOpm  = 5'd1;
        step();
        chk("rd_hold0", 64'(mmio.mmioOK), 64'(HLD));
        setDev(2, HLD, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_hold", 64'(mmio.mmioOK), 64'(HLD));
        end
        setDev(2, OKV, 64'h1122334455667788);
        step();
        chk("rd_ok", 64'(mmio.mmioOK), 64'(OKV));
        chk("rd_data", mmio.mmioInData, 64'h1122334455667788);
        clrDev();
        mmio.mmioAddr = 32'h0000_2000;
        setDev(5, OKV, 64'h99);
        step();
        chk("rd_stable_ok", 64'(mmio.mmioOK), 64'(OKV));
        chk("rd_stable_data", mmio.mmioInData, 64'h1122334455667788);
        clrDev();
        mmio.mmioOpm = 5'd0;
        step();
        chk("rd_done", 64'(mmio.mmioOK), 64'(RDY));
        chk("rd_coll", 64'(collisionFlag), 64'h0);

        // first miss
        mmio.mmioAddr = 32'hF00B_0000;
        mmio.mmioOpm  = 5'd2;
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("miss_pre", 64'(mmio.mmioOK), 64'(HLD));
        chk("miss_preflag", 64'(busMissFlag), 64'h0);
        step();
        chk("miss_ok", 64'(mmio.mmioOK), 64'(FLT));
        chk("miss_data", mmio.mmioInData, 64'h0);
        chk("miss_flag", 64'(busMissFlag), 64'h1);
        chk("miss_addr", 64'(busMissAddr), 64'hF00B_0000);
        mmio.mmioOpm = 5'd0;
        step();
        chk("miss_done", 64'(mmio.mmioOK), 64'(RDY));

        // second miss keeps first address
        mmio.mmioAddr = 32'hF00C_0000;
        mmio.mmioOpm  = 5'd2;
        step();
        for (int i = 0; i < TIMEOUT; i++) step();
        chk("miss2_ok", 64'(mmio.mmioOK), 64'(FLT));
        chk("miss2_addr", 64'(busMissAddr), 64'hF00B_0000);
        mmio.mmioOpm = 5'd0;
        step();

        // collision on channels 1 and 4
        mmio.mmioAddr = 32'h0000_3000;
        mmio.mmioOpm  = 5'd1;
        step();
        setDev(1, OKV, 64'hA);
        setDev(4, OKV, 64'hB);
        step();
        chk("col_ok", 64'(mmio.mmioOK), 64'(OKV));
        chk("col_data", mmio.mmioInData, 64'hA);
        chk("col_flag", 64'(collisionFlag), 64'h1);
        clrDev();
        mmio.mmioOpm = 5'd0;
        step();
        chk("col_done", 64'(mmio.mmioOK), 64'(RDY));
        chk("col_sticky", 64'(collisionFlag), 64'h1);
        statClear = 1'b1;
        step();
        statClear = 1'b0;
        chk("clr_coll", 64'(collisionFlag), 64'h0);
        chk("clr_miss", 64'(busMissFlag), 64'h0);
        chk("clr_maddr", 64'(busMissAddr), 64'h0);

        // long device HOLD never times out
        mmio.mmioAddr = 32'h0000_4000;
        mmio.mmioOpm  = 5'd1;
        step();
        setDev(3, HLD, 64'h0);
        for (int i = 0; i < 1000; i++) step();
        chk("lh_hold", 64'(mmio.mmioOK), 64'(HLD));
        chk("lh_noflag", 64'(busMissFlag), 64'h0);
        setDev(3, FLT, 64'hDEAD);
        step();
        chk("lh_fault", 64'(mmio.mmioOK), 64'(FLT));
        chk("lh_data", mmio.mmioInData, 64'hDEAD);
        chk("lh_flag", 64'(busMissFlag), 64'h0);
        clrDev();
        mmio.mmioOpm = 5'd0;
        step();
        chk("lh_done", 64'(mmio.mmioOK), 64'(RDY));

        // reset mid-WAIT aborts without a clock edge
        mmio.mmioAddr = 32'h0000_5000;
        mmio.mmioOpm  = 5'd1;
        step();
        setDev(0, HLD, 64'h0);
        setDev(5, HLD, 64'h0);
        step();
        chk("ar_hold", 64'(mmio.mmioOK), 64'(HLD));
        chk("ar_coll", 64'(collisionFlag), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_ok", 64'(mmio.mmioOK), 64'(RDY));
        chk("ar_coll0", 64'(collisionFlag), 64'h0);
        chk("ar_miss0", 64'(busMissFlag), 64'h0);
        clrDev();
        mmio.mmioOpm = 5'd0;
        step();
        reset = 1'b0;
        step();
        chk("ar_idle", 64'(mmio.mmioOK), 64'(RDY));
        mmio.mmioOpm = 5'd1;
        step();
        chk("ar_newreq", 64'(mmio.mmioOK), 64'(HLD));
        setDev(7, OKV, 64'h77);
        step();
        chk("ar_resp", mmio.mmioInData, 64'h77);
        clrDev();
        mmio.mmioOpm = 5'd0;
        step();

`ifdef MMIO_FABRIC_IRQ_EN
        tickIrq   = 1'b1;
        irqReq[3] = 1'b1;
        step();
        chk("irq_tick", busExc, 64'hC001);
        tickIrq = 1'b0;
        step();
        chk("irq_dev3", busExc, 64'hC005);
        irqReq = '0;
        step();
        chk("irq_none", busExc, 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
